// File: rtl/xrisc_dmem_responder_if.sv
// rtl/xrisc_dmem_responder_if.sv - store/load bus, write-log stream and test-status bundle for the dmem responder
interface xrisc_dmem_responder_if #(
    parameter int LOG_DEPTH = 8
);
    localparam int CW = $clog2(LOG_DEPTH) + 1;

    logic          MemWrite;
    logic [31:0]   DataAdr;
    logic [31:0]   WriteData;
    logic [31:0]   ReadData;
    logic          log_valid;
    logic          log_ready;
    logic [31:0]   log_addr;
    logic [31:0]   log_data;
    logic [CW-1:0] log_count;
    logic          log_overflow;
    logic          misaligned;
    logic          done;
    logic          pass;
    logic [30:0]   fail_code;

    modport master (
        output MemWrite, DataAdr, WriteData, log_ready,
        input  ReadData, log_valid, log_addr, log_data, log_count,
               log_overflow, misaligned, done, pass, fail_code
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, log_ready,
        output ReadData, log_valid, log_addr, log_data, log_count,
               log_overflow, misaligned, done, pass, fail_code
    );
endinterface

// File: rtl/xrisc_dmem_responder.sv
// rtl/xrisc_dmem_responder.sv - data RAM, TOHOST result register and store write-log FIFO for the XRISC core
module xrisc_dmem_responder #(
    parameter int          DEPTH       = 64,
    parameter int          LOG_DEPTH   = 8,
    parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0
) (
    input logic                    clk,
    input logic                    reset,
    xrisc_dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(LOG_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem   [DEPTH];
    logic [31:0]   log_a [LOG_DEPTH];
    logic [31:0]   log_d [LOG_DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr, head_ptr;
    logic [CW-1:0] count;
    logic          overflow_q, misaligned_q, done_q, pass_q;
    logic [30:0]   fail_q;
    logic [31:0]   read_data;

    logic          aligned, in_ram, at_tohost, full, push, pop, accept;
    logic [AW-1:0] idx;

    assign idx       = bus.DataAdr[AW+1:2];
    assign aligned   = (bus.DataAdr[1:0] == 2'b00);
    assign in_ram    = (bus.DataAdr < 32'(DEPTH * 4));
    assign at_tohost = (bus.DataAdr == TOHOST_ADDR);
    assign full      = (count == CW'(LOG_DEPTH));
    assign push      = bus.MemWrite;
    assign pop       = (count != '0) && bus.log_ready;
    // A full log still takes a push when the head leaves on the same edge.
    assign accept    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset && bus.MemWrite && aligned && in_ram)
            mem[idx] <= bus.WriteData;
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            log_a[wr_ptr] <= bus.DataAdr;
            log_d[wr_ptr] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_q   <= 1'b0;
            misaligned_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop)
                count <= count + CW'(1);
            else if (!accept && pop)
                count <= count - CW'(1);
            if (push && full && !pop)
                overflow_q <= 1'b1;
            if (bus.MemWrite && !aligned)
                misaligned_q <= 1'b1;
            if (bus.MemWrite && aligned && at_tohost && !done_q && bus.WriteData != 32'd0) begin
                done_q <= 1'b1;
                pass_q <= (bus.WriteData == 32'd1);
                fail_q <= bus.WriteData[31:1];
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (in_ram)
            read_data = mem[idx];
        else if (at_tohost && done_q)
            read_data = pass_q ? 32'd1 : {fail_q, 1'b0};
    end

    // When empty, point at the slot just popped so the head outputs hold their last value.
    assign head_ptr = (count != '0) ? rd_ptr : rd_ptr - PW'(1);

    assign bus.ReadData     = read_data;
    assign bus.log_valid    = (count != '0);
    assign bus.log_addr     = log_a[head_ptr];
    assign bus.log_data     = log_d[head_ptr];
    assign bus.log_count    = count;
    assign bus.log_overflow = overflow_q;
    assign bus.misaligned   = misaligned_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.fail_code    = fail_q;
endmodule

// File: tb/tb_xrisc_dmem_responder.sv
// tb/tb_xrisc_dmem_responder.sv - scoreboard bench for the XRISC dmem responder
module tb_xrisc_dmem_responder;
    localparam int          LD     = 4;
    localparam logic [31:0] TOHOST = 32'hFFFF_FFF0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xrisc_dmem_responder_if #(.LOG_DEPTH(LD)) bus ();

    xrisc_dmem_responder #(
        .DEPTH(64),
        .LOG_DEPTH(LD),
        .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    logic        exp_ovf = 1'b0;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.MemWrite = 1'b0;
        bus.log_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        logic [63:0] h;
        bus.MemWrite = 1'b1;
        bus.DataAdr = a;
        bus.WriteData = d;
        bus.log_ready = rdy;
        #1;
        if (rdy && exp_q.size() > 0) begin
            h = exp_q.pop_front();
            total++;
            if ({bus.log_addr, bus.log_data} !== h) begin
                bad++;
                $display("FAIL pop_head got %h exp %h", {bus.log_addr, bus.log_data}, h);
            end
        end
        if (exp_q.size() < LD) exp_q.push_back({a, d});
        else exp_ovf = 1'b1;
        tick();
        bus.MemWrite = 1'b0;
        bus.log_ready = 1'b0;
    endtask

    task automatic drain;
        logic [63:0] h;
        bus.log_ready = 1'b1;
        for (int n = 0; n < 2 * LD && exp_q.size() > 0; n++) begin
            #1;
            h = exp_q.pop_front();
            total++;
            if (bus.log_valid !== 1'b1) begin bad++; $display("FAIL drain_valid got %b exp 1", bus.log_valid); end
            total++;
            if ({bus.log_addr, bus.log_data} !== h) begin
                bad++;
                $display("FAIL drain_head got %h exp %h", {bus.log_addr, bus.log_data}, h);
            end
            tick();
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL drain_timeout left %0d exp 0", exp_q.size()); end
        exp_q.delete();
        bus.log_ready = 1'b0;
        #1;
        total++;
        if (bus.log_valid !== 1'b0) begin bad++; $display("FAIL drain_empty_valid got %b exp 0", bus.log_valid); end
        total++;
        if (bus.log_count !== 3'd0) begin bad++; $display("FAIL drain_empty_count got %0d exp 0", bus.log_count); end
        total++;
        if (bus.log_overflow !== exp_ovf) begin bad++; $display("FAIL drain_overflow got %b exp %b", bus.log_overflow, exp_ovf); end
    endtask

    task automatic test_reset;
        bus.MemWrite = 1'b0;
        bus.DataAdr = 32'h0;
        bus.WriteData = 32'h0;
        bus.log_ready = 1'b0;
        tick();
        reset = 1'b0;
        store(32'h64, 32'h5A5A, 1'b0);
        reset = 1'b1;
        bus.MemWrite = 1'b1;
        bus.DataAdr = 32'h64;
        bus.WriteData = 32'h19;
        tick();
        tick();
        bus.MemWrite = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        #1;
        total++; if (bus.log_count !== 3'd0) begin bad++; $display("FAIL rst_count got %0d exp 0", bus.log_count); end
        total++; if (bus.log_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b exp 0", bus.log_valid); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got %b exp 0", bus.done); end
        total++; if (bus.pass !== 1'b0) begin bad++; $display("FAIL rst_pass got %b exp 0", bus.pass); end
        total++; if (bus.log_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got %b exp 0", bus.log_overflow); end
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL rst_misaligned got %b exp 0", bus.misaligned); end
        total++; if (bus.ReadData !== 32'h5A5A) begin bad++; $display("FAIL rst_ram_kept got %h exp 5a5a", bus.ReadData); end
    endtask

    task automatic test_store_read;
        store(32'h64, 32'h19, 1'b0);
        #1;
        total++; if (bus.ReadData !== 32'h19) begin bad++; $display("FAIL rd_after_wr got %h exp 19", bus.ReadData); end
        total++; if (bus.log_valid !== 1'b1) begin bad++; $display("FAIL head_valid got %b exp 1", bus.log_valid); end
        total++; if (bus.log_addr !== 32'h64) begin bad++; $display("FAIL head_addr got %h exp 64", bus.log_addr); end
        total++; if (bus.log_data !== 32'h19) begin bad++; $display("FAIL head_data got %h exp 19", bus.log_data); end
        drain();
        total++; if (bus.log_addr !== 32'h64) begin bad++; $display("FAIL empty_hold_addr got %h exp 64", bus.log_addr); end
        store(32'h1064, 32'hBEEF, 1'b0);
        bus.DataAdr = 32'h64;
        #1;
        total++; if (bus.ReadData !== 32'h19) begin bad++; $display("FAIL no_alias got %h exp 19", bus.ReadData); end
        bus.DataAdr = 32'h1064;
        #1;
        total++; if (bus.ReadData !== 32'h0) begin bad++; $display("FAIL oor_read got %h exp 0", bus.ReadData); end
        drain();
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 1; i <= 5; i++) store(32'(i * 4), 32'(i), 1'b0);
        #1;
        total++; if (bus.log_count !== 3'd4) begin bad++; $display("FAIL ovf_count got %0d exp 4", bus.log_count); end
        total++; if (bus.log_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b exp 1", bus.log_overflow); end
        drain();
    endtask

    task automatic test_full_push_pop;
        do_reset();
        for (int i = 1; i <= 4; i++) store(32'(i * 4), 32'(i), 1'b0);
        store(32'h40, 32'd9, 1'b1);
        #1;
        total++; if (bus.log_count !== 3'd4) begin bad++; $display("FAIL fpp_count got %0d exp 4", bus.log_count); end
        total++; if (bus.log_overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got %b exp 0", bus.log_overflow); end
        drain();
    endtask

    task automatic test_tohost;
        do_reset();
        store(TOHOST, 32'd0, 1'b1);
        #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL th_zero_done got %b exp 0", bus.done); end
        store(TOHOST, 32'd1, 1'b1);
        #1;
        total++; if ({bus.done, bus.pass} !== 2'b11) begin bad++; $display("FAIL th_pass got %b exp 11", {bus.done, bus.pass}); end
        total++; if (bus.ReadData !== 32'd1) begin bad++; $display("FAIL th_rd_pass got %h exp 1", bus.ReadData); end
        store(TOHOST, 32'd7, 1'b1);
        #1;
        total++; if ({bus.pass, bus.fail_code} !== {1'b1, 31'd0}) begin bad++; $display("FAIL th_sticky got %h exp 80000000", {bus.pass, bus.fail_code}); end
        drain();
        do_reset();
        store(TOHOST, 32'd7, 1'b1);
        #1;
        total++; if ({bus.done, bus.pass} !== 2'b10) begin bad++; $display("FAIL th_fail got %b exp 10", {bus.done, bus.pass}); end
        total++; if (bus.fail_code !== 31'd3) begin bad++; $display("FAIL th_code7 got %0d exp 3", bus.fail_code); end
        total++; if (bus.ReadData !== 32'd6) begin bad++; $display("FAIL th_rd_fail got %h exp 6", bus.ReadData); end
        drain();
        do_reset();
        store(TOHOST, 32'd8, 1'b1);
        #1;
        total++; if ({bus.done, bus.pass, bus.fail_code} !== {2'b10, 31'd4}) begin bad++; $display("FAIL th_even got %h exp 4", {bus.done, bus.pass, bus.fail_code}); end
        drain();
        do_reset();
        store(TOHOST + 32'd2, 32'd1, 1'b1);
        #1;
        total++; if ({bus.done, bus.misaligned} !== 2'b01) begin bad++; $display("FAIL th_misaligned got %b exp 01", {bus.done, bus.misaligned}); end
        drain();
    endtask

    task automatic test_misaligned;
        do_reset();
        store(32'h64, 32'h1234, 1'b0);
        #1;
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL mis_clear got %b exp 0", bus.misaligned); end
        store(32'h66, 32'hDEAD, 1'b0);
        bus.DataAdr = 32'h64;
        #1;
        total++; if (bus.ReadData !== 32'h1234) begin bad++; $display("FAIL mis_ram got %h exp 1234", bus.ReadData); end
        total++; if (bus.misaligned !== 1'b1) begin bad++; $display("FAIL mis_flag got %b exp 1", bus.misaligned); end
        drain();
    endtask

    initial begin
        test_reset();
        test_store_read();
        test_overflow();
        test_full_push_pop();
        test_tohost();
        test_misaligned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
